// File: rtl/demux2_1_stream.sv
// Two-way valid/ready stream demultiplexer with per-channel one-entry output slices.
// Optional per-channel saturating beat counters are built when DEMUX2_1_STREAM_CNT_EN is defined.
module demux2_1_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX2_1_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1} state_e;

  if (WIDTH < 1) begin : g_bad_width
    $error("demux2_1_stream: WIDTH must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("demux2_1_stream: CNT_W must be >= 1");
  end

  state_e           state_q, state_d;
  logic             route;
  logic             accept;
  logic             load0, load1;
  logic [WIDTH-1:0] out0_data_q, out0_data_d, out1_data_q, out1_data_d;
  logic             out0_last_q, out0_last_d, out1_last_q, out1_last_d;
  logic             out0_valid_q, out0_valid_d, out1_valid_q, out1_valid_d;

  // Route is live from in_sel only between packets; in_valid never feeds in_ready.
  always_comb begin
    route = in_sel;
    if (state_q == ROUTE0) route = 1'b0;
    else if (state_q == ROUTE1) route = 1'b1;

    in_ready = route ? (~out1_valid_q | out1_ready) : (~out0_valid_q | out0_ready);
    accept   = in_valid & in_ready;
    load0    = accept & ~route;
    load1    = accept & route;

    state_d = state_q;
    if (accept) begin
      if (in_last) state_d = IDLE;
      else         state_d = route ? ROUTE1 : ROUTE0;
    end

    out0_valid_d = load0 | (out0_valid_q & ~out0_ready);
    out0_data_d  = load0 ? in_data : out0_data_q;
    out0_last_d  = load0 ? in_last : out0_last_q;
    out1_valid_d = load1 | (out1_valid_q & ~out1_ready);
    out1_data_d  = load1 ? in_data : out1_data_q;
    out1_last_d  = load1 ? in_last : out1_last_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      out0_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out0_last_q  <= 1'b0;
      out1_valid_q <= 1'b0;
      out1_data_q  <= '0;
      out1_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      out0_valid_q <= out0_valid_d;
      out0_data_q  <= out0_data_d;
      out0_last_q  <= out0_last_d;
      out1_valid_q <= out1_valid_d;
      out1_data_q  <= out1_data_d;
      out1_last_q  <= out1_last_d;
    end
  end

  assign out0_data  = out0_data_q;
  assign out0_last  = out0_last_q;
  assign out0_valid = out0_valid_q;
  assign out1_data  = out1_data_q;
  assign out1_last  = out1_last_q;
  assign out1_valid = out1_valid_q;

`ifdef DEMUX2_1_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Counters track delivered beats and stick at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (out0_valid_q && out0_ready && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + CNT_W'(1);
    if (out1_valid_q && out1_ready && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_1_stream.sv
// Bench for demux2_1_stream: vector table plus hand sequences, checked by per-channel scoreboards.
module tb_demux2_1_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel, in_last, in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_last, out1_last, out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
`ifdef DEMUX2_1_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt0, cnt1;
`endif

  demux2_1_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_last(out0_last),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_last(out1_last),
    .out1_valid(out1_valid), .out1_ready(out1_ready)
`ifdef DEMUX2_1_STREAM_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [WIDTH:0] q0[$];
  logic [WIDTH:0] q1[$];

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             sel;
    logic             last;
    logic             exp_ch;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: whenever a slice is valid it must show the scoreboard head.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (out0_valid) begin
        if (q0.size() == 0) chk("out0_unexpected_valid", 1, 0);
        else begin
          chk("out0_beat", {out0_last, out0_data}, q0[0]);
          if (out0_ready) void'(q0.pop_front());
        end
      end else if (q0.size() != 0) chk("out0_missing_beat", 0, 1);
      if (out1_valid) begin
        if (q1.size() == 0) chk("out1_unexpected_valid", 1, 0);
        else begin
          chk("out1_beat", {out1_last, out1_data}, q1[0]);
          if (out1_ready) void'(q1.pop_front());
        end
      end else if (q1.size() != 0) chk("out1_missing_beat", 0, 1);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
  task automatic send(input logic [WIDTH-1:0] d, input logic s, input logic l,
                      input logic ch, input logic must_rdy);
    int  n;
    logic acc;
    in_data = d; in_sel = s; in_last = l; in_valid = 1'b1;
    n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (must_rdy && n == 0) chk("in_ready_throughput", in_ready, 1);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        if (ch) q1.push_back({l, d});
        else    q0.push_back({l, d});
      end
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    in_sel   = 1'($urandom);
    in_last  = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out0_valid"}, out0_valid, 0);
    chk({tag, "_out1_valid"}, out1_valid, 0);
    chk({tag, "_out0_data"}, out0_data, 0);
    chk({tag, "_out1_data"}, out1_data, 0);
    chk({tag, "_out0_last"}, out0_last, 0);
    chk({tag, "_out1_last"}, out1_last, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
`ifdef DEMUX2_1_STREAM_CNT_EN
    chk({tag, "_cnt0"}, cnt0, 0);
    chk({tag, "_cnt1"}, cnt1, 0);
`endif
  endtask

  task automatic mid_reset();
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    q0.delete();
    q1.delete();
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h02, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h03, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'h44, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h55, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h66, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{8'h77, 1'b0, 1'b1, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 1'b0; in_last = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    #3 check_reset_outputs("init_reset");
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // Single-beat routing and route lock at full throughput.
    for (int i = 0; i < 9; i++) send(vecs[i].data, vecs[i].sel, vecs[i].last, vecs[i].exp_ch, 1'b1);
    idle(3);

    // Backpressure on an open out0 packet, then drain-and-reload.
    out0_ready = 1'b0;
    send(8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    in_data = 8'h81; in_sel = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out0_data", out0_data, 8'h80);
      @(posedge clk); #1;
    end
    out0_ready = 1'b1;
    send(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h82, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("reload_out0_valid", out0_valid, 1);
    chk("reload_out0_data", out0_data, 8'h82);
    send(8'h83, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);

    // Independent drain of out1 while out0 is stalled.
    out0_ready = 1'b0;
    send(8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'h22, 1'b1, 1'b1, 1'b1, 1'b1);
    in_data = 8'h33; in_sel = 1'b0; in_last = 1'b1;
    @(negedge clk);
    chk("indep_out1_valid", out1_valid, 1);
    chk("indep_out1_data", out1_data, 8'h22);
    chk("indep_out0_hold", {out0_valid, out0_data}, {1'b1, 8'h11});
    chk("indep_in_ready_blocked", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stalled_route_other_empty", in_ready, 0);
    chk("out1_drained", out1_valid, 0);
    @(posedge clk); #1;
    out0_ready = 1'b1;
    send(8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Reset mid-packet drops the open route.
    out0_ready = 1'b0;
    send(8'h90, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    mid_reset();
    out0_ready = 1'b1;
    send(8'hB1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);

`ifdef DEMUX2_1_STREAM_CNT_EN
    mid_reset();
    idle(1);
    for (int i = 0; i < 5; i++) send(8'hD0 + 8'(i), 1'b1, 1'b1, 1'b1, 1'b1);
    idle(2);
    chk("cnt1_after_5", cnt1, 5);
    for (int i = 5; i < 20; i++) send(8'hD0 + 8'(i), 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);
    chk("cnt1_saturated", cnt1, 15);
    chk("cnt0_untouched", cnt0, 0);
`endif

    idle(3);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
